// File: rtl/qpd_request_sequencer_if.sv
// Handshake bundle between the config/delay-block side and qpd_request_sequencer.
// The sequencer uses the slave modport; the request/trigger source uses master.
interface qpd_request_sequencer_if;
    logic        start;
    logic [7:0]  req_count;
    logic [7:0]  count_quater_period;
    logic        rt;
    logic        trigger;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic [15:0] latency;
    logic        stray;
    logic        lat_err;

    modport master (
        output start, req_count, trigger,
        input  count_quater_period, rt, busy, done, status, latency, stray, lat_err
    );

    modport slave (
        input  start, req_count, trigger,
        output count_quater_period, rt, busy, done, status, latency, stray, lat_err
    );
endinterface

// File: rtl/qpd_request_sequencer.sv
// Quarter-period-delay request initiator: sends a delay word plus rt strobe, times the returned trigger.
// Optional latency check is built when QPD_SEQ_LAT_CHECK_EN is defined; otherwise lat_err is tied 0.
module qpd_request_sequencer #(
    parameter int unsigned RT_CYCLES      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned PIPE_LAT       = 2
) (
    input logic                    sclock,
    input logic                    rstn,
    qpd_request_sequencer_if.slave qif
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ASSERT, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {ST_OK = 2'd0, ST_TIMEOUT = 2'd1, ST_DUP_SKIP = 2'd2} status_t;

    localparam logic [15:0] RT_LAST      = 16'(RT_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nx;
    logic        trig_q;
    logic        rise;
    logic [7:0]  req_q;
    logic [7:0]  cqp;
    logic [15:0] phase_cnt;
    logic [15:0] lat_cnt;
    status_t     status_r;
    logic [15:0] latency_r;
    logic        stray_r;

    logic        accept;
    logic        fin;
    status_t     fin_status;
    logic [15:0] fin_latency;

    assign rise = qif.trigger & ~trig_q;

    always_comb begin
        state_nx    = state;
        accept      = 1'b0;
        fin         = 1'b0;
        fin_status  = ST_OK;
        fin_latency = '0;
        case (state)
            S_IDLE: begin
                if (qif.start) begin
                    accept = 1'b1;
                    // The delay block only arms on a changed word, so a repeat is skipped.
                    if (qif.req_count == cqp) begin
                        state_nx   = S_DONE;
                        fin        = 1'b1;
                        fin_status = ST_DUP_SKIP;
                    end else begin
                        state_nx = S_LOAD;
                    end
                end
            end
            S_LOAD: state_nx = S_ASSERT;
            S_ASSERT: begin
                if (rise) begin
                    state_nx    = S_DONE;
                    fin         = 1'b1;
                    fin_latency = lat_cnt;
                end else if (phase_cnt == RT_LAST) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rise) begin
                    state_nx    = S_DONE;
                    fin         = 1'b1;
                    fin_latency = lat_cnt;
                end else if (phase_cnt == TIMEOUT_LAST) begin
                    state_nx    = S_DONE;
                    fin         = 1'b1;
                    fin_status  = ST_TIMEOUT;
                    fin_latency = '1;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge sclock or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            trig_q    <= 1'b0;
            req_q     <= '0;
            cqp       <= '0;
            phase_cnt <= '0;
            lat_cnt   <= '0;
            status_r  <= ST_OK;
            latency_r <= '0;
            stray_r   <= 1'b0;
        end else begin
            state  <= state_nx;
            trig_q <= qif.trigger;
            if (accept)
                req_q <= qif.req_count;
            if (state == S_LOAD)
                cqp <= req_q;

            // phase_cnt times the rt window, then restarts to time the WAIT window.
            if (state == S_LOAD || (state == S_ASSERT && state_nx == S_WAIT))
                phase_cnt <= '0;
            else if (state == S_ASSERT || state == S_WAIT)
                phase_cnt <= phase_cnt + 16'd1;

            if (state == S_LOAD)
                lat_cnt <= '0;
            else if ((state == S_ASSERT || state == S_WAIT) && lat_cnt != '1)
                lat_cnt <= lat_cnt + 16'd1;

            if (fin) begin
                status_r  <= fin_status;
                latency_r <= fin_latency;
            end

            if (rise && (state == S_IDLE || state == S_LOAD || state == S_DONE))
                stray_r <= 1'b1;
            else if (accept)
                stray_r <= 1'b0;
        end
    end

    assign qif.count_quater_period = cqp;
    assign qif.rt                  = (state == S_ASSERT);
    assign qif.busy                = (state != S_IDLE);
    assign qif.done                = (state == S_DONE);
    assign qif.status              = status_r;
    assign qif.latency             = latency_r;
    assign qif.stray               = stray_r;

`ifdef QPD_SEQ_LAT_CHECK_EN
    logic lat_err_r;

    always_ff @(posedge sclock or negedge rstn) begin
        if (!rstn)
            lat_err_r <= 1'b0;
        else if (fin)
            lat_err_r <= (fin_status == ST_OK) &&
                         (fin_latency != ({8'd0, req_q} + 16'(PIPE_LAT)));
    end

    assign qif.lat_err = lat_err_r;
`else
    logic unused_pipe_lat;
    assign unused_pipe_lat = (PIPE_LAT != 0);
    assign qif.lat_err     = 1'b0;
`endif

endmodule

// File: tb/tb_qpd_request_sequencer.sv
// Self-checking bench for qpd_request_sequencer: directed steps plus randomized requests
// compared against an outcome model derived from request timing rules.
module tb_qpd_request_sequencer;

    localparam int unsigned RT   = 4;
    localparam int unsigned TO   = 1024;
    localparam int unsigned PIPE = 2;
`ifdef QPD_SEQ_LAT_CHECK_EN
    localparam bit LAT_CHK = 1'b1;
`else
    localparam bit LAT_CHK = 1'b0;
`endif

    logic sclock;
    logic rstn;

    qpd_request_sequencer_if qif ();

    qpd_request_sequencer #(
        .RT_CYCLES      (RT),
        .TIMEOUT_CYCLES (TO),
        .PIPE_LAT       (PIPE)
    ) dut (
        .sclock (sclock),
        .rstn   (rstn),
        .qif    (qif)
    );

    initial sclock = 1'b0;
    always #5 sclock = ~sclock;

    int unsigned passed;
    int unsigned total;
    logic [7:0]  m_cqp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One request starting at the next negedge. Trigger pulse covers cycles [2+d, 2+d+w)
    // counted from the start cycle (cycle 0); first rt-high cycle is cycle 2.
    task automatic run_req(input logic [7:0] req, input bit has_trig, input int unsigned d,
                           input int unsigned w, input bit extra_start, input string tag);
        bit          dup;
        int unsigned exp_done, exp_rt, done_c, rt_seen, busy_low, pstart, pend;
        logic [1:0]  exp_st;
        logic [15:0] exp_lat;
        logic        exp_err, exp_stray;

        dup = (req == m_cqp);
        if (dup) begin
            exp_done = 1; exp_st = 2'd2; exp_lat = 16'd0; exp_rt = 0;
            exp_err = 1'b0; exp_stray = 1'b0;
        end else begin
            m_cqp = req;
            if (has_trig && d < RT + TO) begin
                exp_done = d + 3; exp_st = 2'd0; exp_lat = 16'(d);
                exp_rt   = (d + 1 < RT) ? d + 1 : RT;
                exp_err  = LAT_CHK && (16'(d) != 16'(req) + 16'(PIPE));
            end else begin
                exp_done = 2 + RT + TO; exp_st = 2'd1; exp_lat = 16'hFFFF;
                exp_rt   = RT; exp_err = 1'b0;
            end
            exp_stray = has_trig && (2 + d >= exp_done);
        end
        pstart = (has_trig && !dup) ? 2 + d : 0;
        pend   = (has_trig && !dup) ? pstart + w : 0;

        @(negedge sclock);
        qif.start     = 1'b1;
        qif.req_count = req;
        done_c = 0; rt_seen = 0; busy_low = 0;
        for (int unsigned c = 1; c <= RT + TO + 10; c++) begin
            @(negedge sclock);
            qif.start     = extra_start && (c == 3);
            qif.req_count = (extra_start && c == 3) ? ~req : req;
            qif.trigger   = (c >= pstart && c < pend);
            if (c == 1) check({tag, "/stray_clr"}, 32'(qif.stray), 32'd0);
            if (qif.rt) rt_seen++;
            if (!qif.busy) busy_low++;
            if (qif.done) begin
                done_c = c;
                break;
            end
        end
        check({tag, "/done_cycle"}, done_c, exp_done);
        check({tag, "/status"}, 32'(qif.status), 32'(exp_st));
        check({tag, "/latency"}, 32'(qif.latency), 32'(exp_lat));
        check({tag, "/lat_err"}, 32'(qif.lat_err), 32'(exp_err));
        check({tag, "/cqp"}, 32'(qif.count_quater_period), 32'(m_cqp));
        check({tag, "/rt_cycles"}, rt_seen, exp_rt);
        check({tag, "/busy_gap"}, busy_low, 32'd0);
        for (int unsigned k = 1; k <= 2; k++) begin
            @(negedge sclock);
            qif.start   = 1'b0;
            qif.trigger = (done_c + k >= pstart && done_c + k < pend);
            if (k == 1) begin
                check({tag, "/busy_after"}, 32'(qif.busy), 32'd0);
                check({tag, "/done_after"}, 32'(qif.done), 32'd0);
                check({tag, "/stray"}, 32'(qif.stray), 32'(exp_stray));
            end
        end
        qif.trigger = 1'b0;
    endtask

    initial begin
        logic [7:0]  r;
        bit          ht;
        int unsigned dd;

        passed = 0; total = 0; m_cqp = 8'd0;
        rstn = 1'b0; qif.start = 1'b0; qif.req_count = 8'd0; qif.trigger = 1'b0;

        repeat (2) @(negedge sclock);
        check("rst/cqp", 32'(qif.count_quater_period), 32'd0);
        check("rst/rt", 32'(qif.rt), 32'd0);
        check("rst/busy", 32'(qif.busy), 32'd0);
        check("rst/done", 32'(qif.done), 32'd0);
        check("rst/status", 32'(qif.status), 32'd0);
        check("rst/latency", 32'(qif.latency), 32'd0);
        check("rst/stray", 32'(qif.stray), 32'd0);
        check("rst/lat_err", 32'(qif.lat_err), 32'd0);
        rstn = 1'b1;
        @(negedge sclock);

        run_req(8'd10, 1'b1, 12, 1, 1'b0, "req10_lat12");
        run_req(8'd10, 1'b1, 5, 1, 1'b0, "dup10");
        run_req(8'd20, 1'b0, 0, 1, 1'b0, "timeout20");

        // Stray pulse while idle, then a request whose start clears it; a mid-request start is ignored.
        @(negedge sclock); qif.trigger = 1'b1;
        @(negedge sclock); qif.trigger = 1'b0;
        @(negedge sclock);
        check("idle_pulse/stray", 32'(qif.stray), 32'd1);
        run_req(8'd30, 1'b1, 5, 1, 1'b1, "req30_busy_start");

        // Boundaries: last ASSERT cycle, first WAIT cycle, level held, last WAIT cycle, just too late.
        run_req(8'd31, 1'b1, 0, 1, 1'b0, "rise_first_rt");
        run_req(8'd32, 1'b1, RT - 1, 1, 1'b0, "rise_last_rt");
        run_req(8'd33, 1'b1, RT, 1, 1'b0, "rise_first_wait");
        run_req(8'd34, 1'b1, 1, 3, 1'b0, "level_hold");
        run_req(8'd35, 1'b1, RT + TO - 1, 1, 1'b0, "rise_last_wait");
        run_req(8'd36, 1'b1, RT + TO, 1, 1'b0, "rise_too_late");

        // Reset in WAIT: outputs drop immediately, no done.
        @(negedge sclock); qif.start = 1'b1; qif.req_count = 8'd40;
        @(negedge sclock); qif.start = 1'b0;
        repeat (19) @(negedge sclock);
        check("midwait/busy_before", 32'(qif.busy), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("midwait/rt", 32'(qif.rt), 32'd0);
        check("midwait/busy", 32'(qif.busy), 32'd0);
        check("midwait/cqp", 32'(qif.count_quater_period), 32'd0);
        check("midwait/done", 32'(qif.done), 32'd0);
        repeat (2) @(negedge sclock);
        rstn  = 1'b1;
        m_cqp = 8'd0;
        @(negedge sclock);
        check("postrst/done", 32'(qif.done), 32'd0);
        run_req(8'd0, 1'b1, 3, 1, 1'b0, "postrst_dup0");

        // Latency-compare cases (lat_err expected 0 unless the check is built).
        run_req(8'd50, 1'b1, 7, 1, 1'b0, "lat_pre");
        run_req(8'd10, 1'b1, 12, 1, 1'b0, "lat_match");
        run_req(8'd50, 1'b1, 7, 1, 1'b0, "lat_mid");
        run_req(8'd10, 1'b1, 13, 1, 1'b0, "lat_mismatch");

        for (int i = 0; i < 40; i++) begin
            r  = ($urandom_range(0, 3) == 0) ? m_cqp : 8'($urandom);
            ht = ($urandom_range(0, 7) != 0);
            dd = $urandom_range(0, 40);
            run_req(r, ht, dd, $urandom_range(1, 2), 1'b0, "rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
